// File: rtl/direct_sound_fifo_channel_if.sv
// Purpose: bundles the FIFO write, playback control and output signals of one
//          Direct Sound channel.
// Ports:   master - register decode / DMA / timer side (drives writes and controls)
//          slave  - channel side (drives wave_l/wave_r, sound_req, level, flags)
interface direct_sound_fifo_channel_if #(
   parameter int unsigned DEPTH_WORDS = 8,
   parameter int unsigned NUM_TIMERS  = 2,
   parameter int unsigned OUT_W       = 24
);
   localparam int unsigned TSEL_W = $clog2(NUM_TIMERS);
   localparam int unsigned LVL_W  = $clog2(DEPTH_WORDS) + 1;

   logic                   fifo_wr;
   logic [31:0]            fifo_wdata;
   logic                   fifo_clear;
   logic [NUM_TIMERS-1:0]  timer_ovf;
   logic [TSEL_W-1:0]      timer_sel;
   logic                   vol_full;
   logic                   en_l;
   logic                   en_r;
   logic [OUT_W-1:0]       wave_l;
   logic [OUT_W-1:0]       wave_r;
   logic                   sound_req;
   logic [LVL_W-1:0]       level;
   logic                   overflow;
   logic                   underflow;

   modport master (
      output fifo_wr, fifo_wdata, fifo_clear, timer_ovf, timer_sel, vol_full, en_l, en_r,
      input  wave_l, wave_r, sound_req, level, overflow, underflow
   );

   modport slave (
      input  fifo_wr, fifo_wdata, fifo_clear, timer_ovf, timer_sel, vol_full, en_l, en_r,
      output wave_l, wave_r, sound_req, level, overflow, underflow
   );
endinterface

// File: rtl/direct_sound_fifo_channel.sv
// Purpose: one GBA Direct Sound channel. Buffers 32-bit writes in a circular
//          word FIFO, plays one signed byte per selected timer overflow, pulses a
//          DMA refill request at the low-water mark and drives scaled L/R outputs.
// Ports:   clock, reset (synchronous, active-low)
//          bus (slave) - fifo_wr/fifo_wdata/fifo_clear, timer_ovf/timer_sel,
//                        vol_full/en_l/en_r in; wave_l/wave_r, sound_req, level,
//                        overflow/underflow out
module direct_sound_fifo_channel #(
   parameter int unsigned DEPTH_WORDS = 8,
   parameter int unsigned REQ_LEVEL   = 4,
   parameter int unsigned NUM_TIMERS  = 2,
   parameter int unsigned OUT_W       = 24
) (
   input  logic                        clock,
   input  logic                        reset,
   direct_sound_fifo_channel_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH_WORDS);
   localparam int unsigned LVL_W = $clog2(DEPTH_WORDS) + 1;

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       sample_q, sample_d;
   logic             sound_req_q, sound_req_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             tick_c;
   logic             play_c;
   logic             retire_c;
   logic             mem_we_c;
   logic [31:0]      head_word_c;
   logic [7:0]       head_byte_c;

   assign tick_c      = bus.timer_ovf[bus.timer_sel];
   assign head_word_c = mem_q[rd_ptr_q];
   assign head_byte_c = head_word_c[{idx_q, 3'b000} +: 8];

   // Next-state: clear dominates; otherwise playback, retire and write combine.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      idx_d       = idx_q;
      sample_d    = sample_q;
      sound_req_d = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      play_c      = 1'b0;
      retire_c    = 1'b0;
      mem_we_c    = 1'b0;

      if (bus.fifo_clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         idx_d       = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         play_c   = tick_c && (level_q != '0);
         retire_c = play_c && (idx_q == 2'd3);
         // A retire frees the head slot this cycle, so a full FIFO still accepts.
         mem_we_c = bus.fifo_wr && ((level_q != LVL_W'(DEPTH_WORDS)) || retire_c);

         if (tick_c && (level_q == '0)) underflow_d = 1'b1;
         if (bus.fifo_wr && !mem_we_c)   overflow_d  = 1'b1;

         if (play_c) begin
            sample_d = head_byte_c;
            idx_d    = idx_q + 2'd1;
         end
         if (retire_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (mem_we_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);

         if (mem_we_c && !retire_c)      level_d = level_q + LVL_W'(1);
         else if (retire_c && !mem_we_c) level_d = level_q - LVL_W'(1);

         sound_req_d = retire_c && (level_d <= LVL_W'(REQ_LEVEL));
      end
   end

   // Control/state registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         idx_q       <= '0;
         sample_q    <= '0;
         sound_req_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         idx_q       <= idx_d;
         sample_q    <= sample_d;
         sound_req_q <= sound_req_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Sample storage; contents need no reset since level gates every read.
   always_ff @(posedge clock) begin
      if (reset && mem_we_c) mem_q[wr_ptr_q] <= bus.fifo_wdata;
   end

   // Output scaling: sample in the top byte, optional arithmetic halve.
   logic signed [OUT_W-1:0] wide_c;
   logic signed [OUT_W-1:0] scaled_c;

   always_comb begin
      wide_c     = {sample_q, {(OUT_W-8){1'b0}}};
      scaled_c   = bus.vol_full ? wide_c : (wide_c >>> 1);
      bus.wave_l = bus.en_l ? scaled_c : '0;
      bus.wave_r = bus.en_r ? scaled_c : '0;
   end

   assign bus.sound_req = sound_req_q;
   assign bus.level     = level_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule
